// File: rtl/pg_sequencer.sv
// pg_sequencer: two-rail power sequencer with debounced PG qualification, ramp timeouts and sticky fault.
// Define PG_SEQ_SYNC_EN to pass PG_A/PG_B through 2-flop synchronizers.
module pg_sequencer #(
    parameter int DEBOUNCE  = 4,
    parameter int TIMEOUT   = 16,
    parameter int OFF_DELAY = 3
) (
    input  logic       CLK,
    input  logic       RESET_B,
    input  logic       REQ,
    input  logic       PG_A,
    input  logic       PG_B,
    input  logic       CLR,
    output logic       EN_A,
    output logic       EN_B,
    output logic       PG,
    output logic       FAULT,
    output logic [2:0] STATE
);
    localparam int CNT_MAX = (TIMEOUT > OFF_DELAY) ? TIMEOUT : OFF_DELAY;
    localparam int CW      = $clog2(CNT_MAX + 1);

    typedef enum logic [2:0] {
        OFF    = 3'd0,
        RAMP_A = 3'd1,
        RAMP_B = 3'd2,
        ON     = 3'd3,
        DOWN_B = 3'd4,
        DOWN_A = 3'd5,
        FLT    = 3'd6
    } state_t;

    state_t        state, state_nx;
    logic [CW-1:0] dcnt, tcnt;
    logic          pg_a, pg_b, pg_sel, qual, tmo, hold_done;
    logic          en_a_nx, en_b_nx, pg_nx, fault_nx;

`ifdef PG_SEQ_SYNC_EN
    logic [1:0] sync_a, sync_b;
    always_ff @(posedge CLK or negedge RESET_B) begin
        if (!RESET_B) begin
            sync_a <= '0;
            sync_b <= '0;
        end else begin
            sync_a <= {sync_a[0], PG_A};
            sync_b <= {sync_b[0], PG_B};
        end
    end
    assign pg_a = sync_a[1];
    assign pg_b = sync_b[1];
`else
    assign pg_a = PG_A;
    assign pg_b = PG_B;
`endif

    // The rail being qualified depends on which ramp step we are in.
    assign pg_sel    = (state == RAMP_B) ? pg_b : pg_a;
    assign qual      = pg_sel && (dcnt == CW'(DEBOUNCE - 1));
    assign tmo       = tcnt == CW'(TIMEOUT - 1);
    assign hold_done = tcnt == CW'(OFF_DELAY - 1);

    always_ff @(posedge CLK or negedge RESET_B) begin
        if (!RESET_B) begin
            state <= OFF;
            dcnt  <= '0;
            tcnt  <= '0;
            EN_A  <= 1'b0;
            EN_B  <= 1'b0;
            PG    <= 1'b0;
            FAULT <= 1'b0;
        end else begin
            state <= state_nx;
            tcnt  <= (state_nx != state) ? '0 : (&tcnt) ? tcnt : tcnt + 1'b1;
            dcnt  <= (state_nx != state || !pg_sel) ? '0 : (&dcnt) ? dcnt : dcnt + 1'b1;
            EN_A  <= en_a_nx;
            EN_B  <= en_b_nx;
            PG    <= pg_nx;
            FAULT <= fault_nx;
        end
    end

    // Faults outrank REQ=0; a completed debounce outranks a coinciding timeout.
    always_comb begin
        state_nx = state;
        case (state)
            OFF:     state_nx = REQ ? RAMP_A : OFF;
            RAMP_A:  state_nx = qual ? RAMP_B : tmo ? FLT : !REQ ? DOWN_A : RAMP_A;
            RAMP_B:  state_nx = !pg_a ? FLT : qual ? ON : tmo ? FLT : !REQ ? DOWN_B : RAMP_B;
            ON:      state_nx = (!pg_a || !pg_b) ? FLT : !REQ ? DOWN_B : ON;
            DOWN_B:  state_nx = hold_done ? DOWN_A : DOWN_B;
            DOWN_A:  state_nx = hold_done ? OFF : DOWN_A;
            FLT:     state_nx = (CLR && !REQ) ? OFF : FLT;
            default: state_nx = OFF;
        endcase
    end

    always_comb begin
        en_a_nx  = state_nx inside {RAMP_A, RAMP_B, ON, DOWN_B};
        en_b_nx  = state_nx inside {RAMP_B, ON};
        pg_nx    = state_nx == ON;
        fault_nx = state_nx == FLT;
    end

    assign STATE = state;
endmodule

// File: tb/tb_pg_sequencer.sv
// tb_pg_sequencer: directed stimulus with a timestamp-based reference model checked every cycle.
module tb_pg_sequencer;
    localparam int DEBOUNCE  = 4;
    localparam int TIMEOUT   = 16;
    localparam int OFF_DELAY = 3;

    logic       CLK = 1'b0, RESET_B = 1'b0, REQ = 1'b0, PG_A = 1'b0, PG_B = 1'b0, CLR = 1'b0;
    logic       EN_A, EN_B, PG, FAULT;
    logic [2:0] STATE;
    int         checks = 0, errors = 0;

    always #5 CLK = ~CLK;

    pg_sequencer #(.DEBOUNCE(DEBOUNCE), .TIMEOUT(TIMEOUT), .OFF_DELAY(OFF_DELAY)) dut (
        .CLK(CLK), .RESET_B(RESET_B), .REQ(REQ), .PG_A(PG_A), .PG_B(PG_B), .CLR(CLR),
        .EN_A(EN_A), .EN_B(EN_B), .PG(PG), .FAULT(FAULT), .STATE(STATE)
    );

    // Model: edge number n, edge at which the current state was entered, and
    // the latest edge at which the watched PG was sampled low.
    int   m_st, m_entry, m_low, m_n, m_nx, low_eff, since;
    logic sel, q, to, hd;

    always_comb begin
        sel     = (m_st == 2) ? PG_B : PG_A;
        low_eff = sel ? m_low : m_n + 1;
        since   = m_n + 1 - ((m_entry > low_eff) ? m_entry : low_eff);
        q       = since >= DEBOUNCE;
        to      = (m_n + 1 - m_entry) >= TIMEOUT;
        hd      = (m_n + 1 - m_entry) >= OFF_DELAY;
        m_nx    = m_st;
        case (m_st)
            0: m_nx = REQ ? 1 : 0;
            1: m_nx = q ? 2 : to ? 6 : !REQ ? 5 : 1;
            2: m_nx = !PG_A ? 6 : q ? 3 : to ? 6 : !REQ ? 4 : 2;
            3: m_nx = (!PG_A || !PG_B) ? 6 : !REQ ? 4 : 3;
            4: m_nx = hd ? 5 : 4;
            5: m_nx = hd ? 0 : 5;
            6: m_nx = (CLR && !REQ) ? 0 : 6;
            default: m_nx = 0;
        endcase
    end

    always @(posedge CLK or negedge RESET_B) begin
        if (!RESET_B) begin
            m_st    <= 0;
            m_entry <= 0;
            m_low   <= 0;
            m_n     <= 0;
        end else begin
            m_n     <= m_n + 1;
            m_st    <= m_nx;
            m_entry <= (m_nx != m_st) ? m_n + 1 : m_entry;
            m_low   <= (m_nx != m_st) ? m_n + 1 : low_eff;
        end
    end

    task automatic check(input string name, input int got, input int exp);
        checks++;
        if (got != exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d at %0t", name, got, exp, $time);
        end
    endtask

    task automatic expect_out(input string tag, input int ea, input int eb, input int pg, input int flt, input int st);
        check({tag, ".en_a"}, int'(EN_A), ea);
        check({tag, ".en_b"}, int'(EN_B), eb);
        check({tag, ".pg"}, int'(PG), pg);
        check({tag, ".fault"}, int'(FAULT), flt);
        check({tag, ".state"}, int'(STATE), st);
    endtask

    task automatic step(input int k);
        repeat (k) @(posedge CLK);
        #1;
    endtask

    initial begin
        fork
            forever begin
                @(negedge CLK);
                check("model.en_a", int'(EN_A), int'(m_st inside {1, 2, 3, 4}));
                check("model.en_b", int'(EN_B), int'(m_st inside {2, 3}));
                check("model.pg", int'(PG), int'(m_st == 3));
                check("model.fault", int'(FAULT), int'(m_st == 6));
                check("model.state", int'(STATE), m_st);
            end
        join_none
        step(2);
        expect_out("reset", 0, 0, 0, 0, 0);
        RESET_B = 1'b1;
        // Nominal power-up
        PG_A = 1'b1; PG_B = 1'b1; REQ = 1'b1;
        step(1); expect_out("up_e0", 1, 0, 0, 0, 1);
        step(3); expect_out("up_e3", 1, 0, 0, 0, 1);
        step(1); expect_out("up_e4", 1, 1, 0, 0, 2);
        step(3); expect_out("up_e7", 1, 1, 0, 0, 2);
        step(1); expect_out("up_e8", 1, 1, 1, 0, 3);
        // Power-down from ON
        REQ = 1'b0;
        step(1); expect_out("dn_m", 1, 0, 0, 0, 4);
        step(2); expect_out("dn_m2", 1, 0, 0, 0, 4);
        step(1); expect_out("dn_m3", 0, 0, 0, 0, 5);
        step(2); expect_out("dn_m5", 0, 0, 0, 0, 5);
        step(1); expect_out("dn_m6", 0, 0, 0, 0, 0);
        // Debounce glitch
        REQ = 1'b1;
        step(1); expect_out("gl_e0", 1, 0, 0, 0, 1);
        step(3); PG_A = 1'b0;
        step(1); expect_out("gl_low", 1, 0, 0, 0, 1);
        PG_A = 1'b1;
        step(3); expect_out("gl_h3", 1, 0, 0, 0, 1);
        step(1); expect_out("gl_h4", 1, 1, 0, 0, 2);
        step(4); expect_out("gl_on", 1, 1, 1, 0, 3);
        // Rail loss in ON
        PG_B = 1'b0;
        step(1); expect_out("loss", 0, 0, 0, 1, 6);
        // Fault clear gating
        CLR = 1'b1; step(1); CLR = 1'b0;
        expect_out("clr_req1", 0, 0, 0, 1, 6);
        REQ = 1'b0;
        step(2); expect_out("flt_hold", 0, 0, 0, 1, 6);
        CLR = 1'b1; step(1); CLR = 1'b0;
        expect_out("clr_ok", 0, 0, 0, 0, 0);
        // Timeout
        PG_A = 1'b0; REQ = 1'b1;
        step(1); expect_out("to_e0", 1, 0, 0, 0, 1);
        step(15); expect_out("to_e15", 1, 0, 0, 0, 1);
        step(1); expect_out("to_e16", 0, 0, 0, 1, 6);
        REQ = 1'b0; CLR = 1'b1; step(1); CLR = 1'b0;
        expect_out("to_clr", 0, 0, 0, 0, 0);
        // REQ withdrawn during RAMP_A
        REQ = 1'b1;
        step(2); expect_out("ab_ramp", 1, 0, 0, 0, 1);
        REQ = 1'b0;
        step(1); expect_out("ab_down", 0, 0, 0, 0, 5);
        step(2); expect_out("ab_hold", 0, 0, 0, 0, 5);
        step(1); expect_out("ab_off", 0, 0, 0, 0, 0);
        // Asynchronous reset mid-RAMP_B
        PG_A = 1'b1; REQ = 1'b1;
        step(5); expect_out("rst_rb", 1, 1, 0, 0, 2);
        #2 RESET_B = 1'b0;
        #1 expect_out("rst_async", 0, 0, 0, 0, 0);
        step(1);
        RESET_B = 1'b1; REQ = 1'b0;
        step(2); expect_out("post_rst", 0, 0, 0, 0, 0);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
